pchigh: RTL and testbench

PCHIGH -- requirements
Module: pchigh

---
 rtl/pchigh_pkg.sv | 19 +
 rtl/pchigh_if.sv | 29 ++
 rtl/pch_stackseq.sv | 77 +++++++
 rtl/pchigh.sv | 88 ++++++++
 tb/tb_pchigh.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pchigh_pkg.sv
// pchigh_pkg: shared 6502 PC definitions used by the PC low/high byte blocks.
//   - pch_state_e : stack sequencer state encoding
//   - VecHiDefault: page loaded into PCH on a reset/IRQ/NMI vector fetch
package pchigh_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPush = 2'd1,
        StPull = 2'd2
    } pch_state_e;

    localparam logic [7:0] VecHiDefault = 8'hFF;

    // Next PCH value on a carry from the low byte, plus the wrap indication.
    function automatic logic [8:0] pch_inc(input logic [7:0] val);
        return {1'b0, val} + 9'd1;
    endfunction

endpackage

// File: rtl/pchigh_if.sv
// pchigh_if: control/data bundle between the CPU sequencer and the PCH block.
//   master: drives adhin, adhwa, pclc, setvec, push, pull, dbin, adhoa, dboa;
//           observes pchc, busy, stkdone.
//   slave : the PCH block (mirror image).
// The tristate bus outputs adhout/dbout are plain ports on pchigh itself.
interface pchigh_if;
    logic [7:0] adhin;
    logic       adhwa;
    logic       pclc;
    logic       setvec;
    logic       push;
    logic       pull;
    logic [7:0] dbin;
    logic       adhoa;
    logic       dboa;
    logic       pchc;
    logic       busy;
    logic       stkdone;

    modport master (
        output adhin, adhwa, pclc, setvec, push, pull, dbin, adhoa, dboa,
        input  pchc, busy, stkdone
    );

    modport slave (
        input  adhin, adhwa, pclc, setvec, push, pull, dbin, adhoa, dboa,
        output pchc, busy, stkdone
    );
endinterface

// File: rtl/pch_stackseq.sv
// pch_stackseq: push/pull sequencer for the PC high byte.
// Each stack operation occupies exactly one cycle after it is requested in IDLE.
//   clk, rst     : clock, asynchronous active-high reset
//   push_i       : request push of PCH (wins over pull)
//   pull_i       : request pull of dbin into PCH
//   busy_o       : high while in PUSH or PULL
//   stkdone_o    : high for the single PUSH/PULL cycle
//   push_drv_o   : PCH must be driven onto dbout this cycle
//   pull_cap_o   : dbin is captured into PCH at the end of this cycle
// All outputs are registered alongside the state.
module pch_stackseq
    import pchigh_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  logic pull_i,
    output logic busy_o,
    output logic stkdone_o,
    output logic push_drv_o,
    output logic pull_cap_o
);

    pch_state_e state_q;
    logic       busy_q;
    logic       stkdone_q;
    logic       push_drv_q;
    logic       pull_cap_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            busy_q     <= 1'b0;
            stkdone_q  <= 1'b0;
            push_drv_q <= 1'b0;
            pull_cap_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (push_i) begin
                        state_q    <= StPush;
                        busy_q     <= 1'b1;
                        stkdone_q  <= 1'b1;
                        push_drv_q <= 1'b1;
                        pull_cap_q <= 1'b0;
                    end else if (pull_i) begin
                        state_q    <= StPull;
                        busy_q     <= 1'b1;
                        stkdone_q  <= 1'b1;
                        push_drv_q <= 1'b0;
                        pull_cap_q <= 1'b1;
                    end else begin
                        state_q    <= StIdle;
                        busy_q     <= 1'b0;
                        stkdone_q  <= 1'b0;
                        push_drv_q <= 1'b0;
                        pull_cap_q <= 1'b0;
                    end
                end
                // PUSH/PULL last one cycle; requests arriving now are dropped.
                default: begin
                    state_q    <= StIdle;
                    busy_q     <= 1'b0;
                    stkdone_q  <= 1'b0;
                    push_drv_q <= 1'b0;
                    pull_cap_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign stkdone_o  = stkdone_q;
    assign push_drv_o = push_drv_q;
    assign pull_cap_o = pull_cap_q;

endmodule

// File: rtl/pchigh.sv
// pchigh: 6502 program counter high byte (PCH).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : pchigh_if.slave control/status bundle
//   adhout   : PCH when bus.adhoa, else high impedance
//   dbout    : PCH when bus.dboa or a push is in progress, else high impedance
// Load priority per edge: adhwa > setvec > pull capture > pclc increment.
// Build option: define PCHIGH_STACK_EN to include the push/pull sequencer;
// without it push/pull/dbin are ignored and busy/stkdone read 0.
module pchigh
    import pchigh_pkg::*;
#(
    parameter logic [7:0] VEC_HI = VecHiDefault
) (
    input  logic       clk,
    input  logic       rst,
    pchigh_if.slave    bus,
    output logic [7:0] adhout,
    output logic [7:0] dbout
);

    logic [7:0] pch_q;
    logic [7:0] pch_d;
    logic       pchc_q;
    logic       pchc_d;
    logic [8:0] pch_inc_val;

    logic busy;
    logic stkdone;
    logic push_drv;
    logic pull_cap;

`ifdef PCHIGH_STACK_EN
    pch_stackseq u_stackseq (
        .clk        (clk),
        .rst        (rst),
        .push_i     (bus.push),
        .pull_i     (bus.pull),
        .busy_o     (busy),
        .stkdone_o  (stkdone),
        .push_drv_o (push_drv),
        .pull_cap_o (pull_cap)
    );
`else
    assign busy     = 1'b0;
    assign stkdone  = 1'b0;
    assign push_drv = 1'b0;
    assign pull_cap = 1'b0;

    logic unused_stack;
    assign unused_stack = ^{bus.push, bus.pull, bus.dbin};
`endif

    assign pch_inc_val = pch_inc(pch_q);

    always_comb begin
        pch_d  = pch_q;
        pchc_d = 1'b0;
        if (bus.adhwa) begin
            pch_d = bus.adhin;
        end else if (bus.setvec) begin
            pch_d = VEC_HI;
        end else if (pull_cap) begin
            pch_d = bus.dbin;
        end else if (bus.pclc) begin
            pch_d  = pch_inc_val[7:0];
            pchc_d = pch_inc_val[8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pch_q  <= 8'h00;
            pchc_q <= 1'b0;
        end else begin
            pch_q  <= pch_d;
            pchc_q <= pchc_d;
        end
    end

    assign bus.pchc    = pchc_q;
    assign bus.busy    = busy;
    assign bus.stkdone = stkdone;

    // During a push dbout carries the value held before this edge's increment.
    assign adhout = bus.adhoa ? pch_q : 8'hzz;
    assign dbout  = (bus.dboa || push_drv) ? pch_q : 8'hzz;

endmodule

// File: tb/tb_pchigh.sv
// tb_pchigh: self-checking bench for pchigh (table vectors, hand sequences,
// randomized run against a behavioural model). Honours PCHIGH_STACK_EN.
module tb_pchigh;
`ifdef PCHIGH_STACK_EN
    localparam bit Stack = 1'b1;
`else
    localparam bit Stack = 1'b0;
`endif
    localparam logic [7:0] Vec = 8'hFF;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    wire  [7:0] adhout;
    wire  [7:0] dbout;

    pchigh_if bus ();

    pchigh #(.VEC_HI(Vec)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus.slave),
        .adhout (adhout),
        .dbout  (dbout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: PCH value, wrap flag, and which stack op (if any)
    // occupies the current cycle: 0 none, 1 push, 2 pull.
    int m_pch;
    int m_pchc;
    int m_op;

    typedef struct {
        logic [7:0] adhin;
        logic       adhwa;
        logic       setvec;
        logic       pclc;
        logic [7:0] exp_pch;
        logic       exp_pchc;
    } vec_t;
    vec_t tbl [11];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // A released bus must not show the PCH value (only testable when PCH != 0).
    task automatic check_rel(input string name, input logic [7:0] act, input logic [7:0] pchv);
        n_checks++;
        if ((pchv != 8'h00) && (act === pchv))
            $display("FAIL %s: got %h, required released bus", name, act);
        else n_pass++;
    endtask

    task automatic set_idle();
        bus.adhin  = 8'h00;
        bus.adhwa  = 1'b0;
        bus.pclc   = 1'b0;
        bus.setvec = 1'b0;
        bus.push   = 1'b0;
        bus.pull   = 1'b0;
        bus.dbin   = 8'h00;
        bus.adhoa  = 1'b0;
        bus.dboa   = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_pch  = 0;
        m_pchc = 0;
        m_op   = 0;
    endtask

    task automatic model_edge();
        int nxt_op;
        nxt_op = 0;
        if (Stack && m_op == 0) nxt_op = bus.push ? 1 : (bus.pull ? 2 : 0);
        m_pchc = 0;
        if (bus.adhwa) m_pch = int'(bus.adhin);
        else if (bus.setvec) m_pch = int'(Vec);
        else if (m_op == 2) m_pch = int'(bus.dbin);
        else if (bus.pclc) begin
            m_pchc = (m_pch == 255) ? 1 : 0;
            m_pch  = (m_pch + 1) % 256;
        end
        m_op = nxt_op;
    endtask

    task automatic model_check();
        logic [7:0] pv;
        pv = 8'(m_pch);
        check8("rand pchc", {7'b0, bus.pchc}, 8'(m_pchc));
        check8("rand busy", {7'b0, bus.busy}, (m_op != 0) ? 8'd1 : 8'd0);
        check8("rand stkdone", {7'b0, bus.stkdone}, (m_op != 0) ? 8'd1 : 8'd0);
        if (bus.adhoa) check8("rand adhout", adhout, pv);
        else check_rel("rand adhout rel", adhout, pv);
        if (bus.dboa || m_op == 1) check8("rand dbout", dbout, pv);
        else check_rel("rand dbout rel", dbout, pv);
    endtask

    initial begin
        tbl[0]  = '{8'hFE, 1'b1, 1'b0, 1'b0, 8'hFE, 1'b0};
        tbl[1]  = '{8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0};
        tbl[2]  = '{8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1};
        tbl[3]  = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[4]  = '{8'h00, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0};
        tbl[5]  = '{8'h12, 1'b1, 1'b1, 1'b1, 8'h12, 1'b0};
        tbl[6]  = '{8'h00, 1'b0, 1'b0, 1'b1, 8'h13, 1'b0};
        tbl[7]  = '{8'h00, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0};
        tbl[8]  = '{8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1};
        tbl[9]  = '{8'h7F, 1'b1, 1'b0, 1'b1, 8'h7F, 1'b0};
        tbl[10] = '{8'h00, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0};

        set_idle();
        bus.adhoa = 1'b1;
        #2;
        check8("reset adhout", adhout, 8'h00);
        check8("reset pchc", {7'b0, bus.pchc}, 8'h00);
        check8("reset busy", {7'b0, bus.busy}, 8'h00);
        check8("reset stkdone", {7'b0, bus.stkdone}, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            set_idle();
            bus.adhin  = tbl[i].adhin;
            bus.adhwa  = tbl[i].adhwa;
            bus.setvec = tbl[i].setvec;
            bus.pclc   = tbl[i].pclc;
            bus.adhoa  = 1'b1;
            step();
            check8($sformatf("vec%0d pch", i), adhout, tbl[i].exp_pch);
            check8($sformatf("vec%0d pchc", i), {7'b0, bus.pchc}, {7'b0, tbl[i].exp_pchc});
        end

        pulse_reset();
        set_idle();
`ifdef PCHIGH_STACK_EN
        // Push of 12, with a pclc increment during the push cycle.
        bus.adhin = 8'h12; bus.adhwa = 1'b1;
        step();
        bus.adhwa = 1'b0; bus.push = 1'b1;
        check8("push pre busy", {7'b0, bus.busy}, 8'h00);
        step();
        bus.pclc = 1'b1;
        check8("push dbout", dbout, 8'h12);
        check8("push stkdone", {7'b0, bus.stkdone}, 8'h01);
        check8("push busy", {7'b0, bus.busy}, 8'h01);
        step();
        bus.push = 1'b0; bus.pclc = 1'b0; bus.adhoa = 1'b1;
        check8("push ignored busy", {7'b0, bus.busy}, 8'h00);
        check8("push stkdone end", {7'b0, bus.stkdone}, 8'h00);
        check_rel("push dbout rel", dbout, 8'h13);
        check8("push inc", adhout, 8'h13);

        // Pull of A5, then pull overridden by adhwa, then by setvec.
        set_idle(); bus.pull = 1'b1;
        step();
        bus.pull = 1'b0; bus.dbin = 8'hA5;
        check8("pull stkdone", {7'b0, bus.stkdone}, 8'h01);
        check8("pull busy", {7'b0, bus.busy}, 8'h01);
        step();
        bus.adhoa = 1'b1;
        check8("pull pch", adhout, 8'hA5);
        check8("pull stkdone end", {7'b0, bus.stkdone}, 8'h00);
        set_idle(); bus.pull = 1'b1;
        step();
        bus.pull = 1'b0; bus.dbin = 8'hA5; bus.adhin = 8'h30; bus.adhwa = 1'b1;
        check8("pull2 stkdone", {7'b0, bus.stkdone}, 8'h01);
        step();
        set_idle(); bus.adhoa = 1'b1;
        check8("pull abort adhwa", adhout, 8'h30);
        check8("pull2 busy end", {7'b0, bus.busy}, 8'h00);
        set_idle(); bus.pull = 1'b1;
        step();
        bus.pull = 1'b0; bus.dbin = 8'h5C; bus.setvec = 1'b1;
        step();
        set_idle(); bus.adhoa = 1'b1;
        check8("pull abort setvec", adhout, 8'hFF);

        // Push and pull together: push taken, nothing captured.
        set_idle(); bus.adhin = 8'h44; bus.adhwa = 1'b1;
        step();
        set_idle(); bus.push = 1'b1; bus.pull = 1'b1; bus.dbin = 8'h99;
        step();
        set_idle(); bus.dbin = 8'h99;
        check8("both dbout", dbout, 8'h44);
        step();
        bus.adhoa = 1'b1;
        check8("both no pull", adhout, 8'h44);
        check8("both busy end", {7'b0, bus.busy}, 8'h00);

        // Reset in the middle of a pull.
        set_idle(); bus.pull = 1'b1;
        step();
        bus.pull = 1'b0; bus.dbin = 8'h5A; bus.adhoa = 1'b1;
        #2 rst = 1'b1;
        #1;
        check8("rst mid-pull pch", adhout, 8'h00);
        check8("rst mid-pull busy", {7'b0, bus.busy}, 8'h00);
        check8("rst mid-pull stkdone", {7'b0, bus.stkdone}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        step();
        check8("rst no capture", adhout, 8'h00);
`else
        // Without the sequencer, push/pull/dbin have no effect.
        bus.adhin = 8'h21; bus.adhwa = 1'b1;
        step();
        set_idle(); bus.push = 1'b1; bus.pull = 1'b1; bus.dbin = 8'h77;
        for (int i = 0; i < 3; i++) begin
            step();
            check8("nostack busy", {7'b0, bus.busy}, 8'h00);
            check8("nostack stkdone", {7'b0, bus.stkdone}, 8'h00);
            check_rel("nostack dbout rel", dbout, 8'h21);
        end
        bus.adhoa = 1'b1;
        #1;
        check8("nostack pch kept", adhout, 8'h21);
        #2 rst = 1'b1;
        #1;
        check8("rst async pch", adhout, 8'h00);
        @(negedge clk);
        rst = 1'b0;
`endif

        pulse_reset();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus.adhin  = 8'($urandom);
            bus.dbin   = 8'($urandom);
            bus.adhwa  = ($urandom_range(0, 7) == 0);
            bus.setvec = ($urandom_range(0, 15) == 0);
            bus.pclc   = ($urandom_range(0, 1) == 0);
            bus.push   = ($urandom_range(0, 5) == 0);
            bus.pull   = ($urandom_range(0, 5) == 0);
            bus.adhoa  = ($urandom_range(0, 1) == 0);
            bus.dboa   = ($urandom_range(0, 3) == 0);
            #1;
            model_check();
            @(posedge clk);
            model_edge();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
